pc_unit: RTL and testbench

Parametrised RISC-V program counter and next-PC generator for the fetch stage.
- Sequential increment by 4, PC-relative branch/JAL, register-indirect JALR and trap redirect, with fixed priority.
- Pipeline stall, with capture of redirects that arrive while stalled.
- Misaligned-target detection that diverts to the trap vector.
- Provides PC, PC+4 (link value) and a registered misalignment flag with the faulting address for the CSR/trap logic.

---
 rtl/pc_unit.sv | 87 ++++++++
 tb/tb_pc_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter and next-PC selection for the fetch stage.
// Redirects that arrive while stalled are parked and replayed when the stall drops.
module pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter logic [XLEN-1:0] TRAP_ADDR  = XLEN'(32'h0000_0100)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            brnch,
  input  logic            jmp,
  input  logic            jalr,
  input  logic            trap,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] PCout,
  output logic [XLEN-1:0] PCplus4,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  logic            pend_valid;
  logic [XLEN-1:0] pend_addr;

  logic            take_ctl;
  logic            new_redir;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] raw_tgt;
  logic            bad_tgt;
  logic [XLEN-1:0] target;

  assign take_ctl  = jalr | jmp | brnch;
  assign new_redir = trap | take_ctl;
  assign rel_tgt   = PCout + imm;
  assign jalr_sum  = rs1 + imm;
  assign jalr_tgt  = jalr_sum & ~XLEN'(1);
  assign raw_tgt   = jalr ? jalr_tgt : rel_tgt;

  // Trap wins outright, so its fixed vector is never subject to the alignment check.
  assign bad_tgt   = !trap && take_ctl && raw_tgt[1];
  assign target    = (trap || bad_tgt) ? TRAP_ADDR : raw_tgt;

  assign PCplus4   = PCout + XLEN'(4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      PCout      <= RESET_ADDR;
      redirect   <= 1'b0;
      misalign   <= 1'b0;
      bad_addr   <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      misalign <= bad_tgt;
      if (bad_tgt) begin
        bad_addr <= raw_tgt;
      end

      if (!stall) begin
        if (new_redir) begin
          PCout      <= target;
          redirect   <= 1'b1;
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          PCout      <= pend_addr;
          redirect   <= 1'b1;
          pend_valid <= 1'b0;
        end else begin
          PCout    <= PCplus4;
          redirect <= 1'b0;
        end
      end else begin
        redirect <= 1'b0;
        // Latest redirect during a stall replaces any earlier parked one.
        if (new_redir) begin
          pend_valid <= 1'b1;
          pend_addr  <= target;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, async reset mid-stall,
// then random stimulus against a behavioural model.
module tb_pc_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clock;
  logic        reset;
  logic        stall, brnch, jmp, jalr, trap;
  logic [31:0] imm, rs1;
  logic [31:0] PCout, PCplus4, bad_addr;
  logic        redirect, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit #(
    .XLEN      (XLEN),
    .RESET_ADDR(32'h0),
    .TRAP_ADDR (TRAP)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .stall   (stall),
    .brnch   (brnch),
    .jmp     (jmp),
    .jalr    (jalr),
    .trap    (trap),
    .imm     (imm),
    .rs1     (rs1),
    .PCout   (PCout),
    .PCplus4 (PCplus4),
    .redirect(redirect),
    .misalign(misalign),
    .bad_addr(bad_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall, brnch, jmp, jalr, trap;
    logic [31:0] imm, rs1;
    logic [31:0] exp_pc;
    logic        exp_red, exp_mis;
    logic [31:0] exp_bad;
  } vec_t;

  vec_t vq[$];

  // Behavioural model state
  logic [31:0] m_pc, m_pa, m_bad;
  logic        m_pv, m_red, m_mis;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic red,
                           input logic mis, input logic [31:0] bad);
    check({tag, " PCout"}, PCout, pc);
    check({tag, " PCplus4"}, PCplus4, pc + 32'd4);
    check({tag, " redirect"}, {31'd0, redirect}, {31'd0, red});
    check({tag, " misalign"}, {31'd0, misalign}, {31'd0, mis});
    check({tag, " bad_addr"}, bad_addr, bad);
  endtask

  task automatic drive(input logic s, input logic b, input logic j, input logic jr,
                       input logic t, input logic [31:0] im, input logic [31:0] r);
    stall = s; brnch = b; jmp = j; jalr = jr; trap = t; imm = im; rs1 = r;
  endtask

  task automatic add(input logic s, input logic b, input logic j, input logic jr,
                     input logic t, input logic [31:0] im, input logic [31:0] r,
                     input logic [31:0] pc, input logic red, input logic mis,
                     input logic [31:0] bad);
    vec_t v;
    v.stall = s; v.brnch = b; v.jmp = j; v.jalr = jr; v.trap = t;
    v.imm = im; v.rs1 = r; v.exp_pc = pc; v.exp_red = red; v.exp_mis = mis; v.exp_bad = bad;
    vq.push_back(v);
  endtask

  // One clock of the architectural rules, applied to the model.
  task automatic model_step();
    logic        req, bad;
    logic [31:0] raw, tgt;
    req = 1'b0; bad = 1'b0; raw = 32'd0; tgt = 32'd0;
    if (trap) begin
      req = 1'b1; tgt = TRAP;
    end else if (jalr || jmp || brnch) begin
      req = 1'b1;
      raw = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (m_pc + imm);
      bad = ((raw >> 1) & 32'd1) != 0;
      tgt = bad ? TRAP : raw;
    end
    m_mis = bad;
    if (bad) m_bad = raw;
    if (!stall) begin
      if (req)       begin m_pc = tgt;  m_red = 1'b1; m_pv = 1'b0; end
      else if (m_pv) begin m_pc = m_pa; m_red = 1'b1; m_pv = 1'b0; end
      else           begin m_pc = m_pc + 32'd4; m_red = 1'b0; end
    end else begin
      m_red = 1'b0;
      if (req) begin m_pv = 1'b1; m_pa = tgt; end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;

    // Directed table, starting right after reset release from PC 0.
    add(0,0,0,0,0, 32'd0,         32'd0,          32'h4,        0,0, 32'h0);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'h8,        0,0, 32'h0);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'hC,        0,0, 32'h0);
    add(0,0,1,0,0, 32'hF4,        32'd0,          32'h100,      1,0, 32'h0);
    add(0,1,0,0,0, 32'hFFFF_FFF0, 32'd0,          32'hF0,       1,0, 32'h0);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'hF4,       0,0, 32'h0);
    add(0,0,0,1,0, 32'd4,         32'h2001,       32'h2004,     1,0, 32'h0);
    add(0,0,0,1,1, 32'd4,         32'h2001,       32'h100,      1,0, 32'h0);
    add(0,0,1,0,0, 32'hFFFF_FF40, 32'd0,          32'h40,       1,0, 32'h0);
    add(0,0,1,0,0, 32'd6,         32'd0,          32'h100,      1,1, 32'h46);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'h104,      0,0, 32'h46);
    add(0,0,0,1,0, 32'd0,         32'h7,          32'h100,      1,1, 32'h6);
    add(0,1,0,0,0, 32'hFFFF_FF80, 32'd0,          32'h80,       1,0, 32'h6);
    add(1,1,0,0,0, 32'h20,        32'd0,          32'h80,       0,0, 32'h6);
    add(1,0,1,0,0, 32'h40,        32'd0,          32'h80,       0,0, 32'h6);
    add(1,0,0,0,0, 32'd0,         32'd0,          32'h80,       0,0, 32'h6);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'hC0,       1,0, 32'h6);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'hC4,       0,0, 32'h6);
    add(1,0,1,0,0, 32'd2,         32'd0,          32'hC4,       0,1, 32'hC6);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'h100,      1,0, 32'hC6);
    add(0,1,1,0,0, 32'd8,         32'd0,          32'h108,      1,0, 32'hC6);
    add(0,0,0,1,0, 32'd0,         32'hFFFF_FFFC,  32'hFFFF_FFFC,1,0, 32'hC6);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'h0,        0,0, 32'hC6);
    add(0,0,0,0,0, 32'd0,         32'd0,          32'h4,        0,0, 32'hC6);

    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].stall, vq[i].brnch, vq[i].jmp, vq[i].jalr, vq[i].trap, vq[i].imm, vq[i].rs1);
      step();
      check_all($sformatf("vec%0d", i), vq[i].exp_pc, vq[i].exp_red, vq[i].exp_mis,
                vq[i].exp_bad);
    end

    // Async reset while stalled with a parked redirect: pending must be discarded.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0);
    step();
    check("stall park PCout", PCout, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    check_all("async reset", 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    check("reset held PCout", PCout, 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    check_all("post reset 1", 32'h4, 1'b0, 1'b0, 32'h0);
    step();
    check_all("post reset 2", 32'h8, 1'b0, 1'b0, 32'h0);

    // Random stimulus against the model.
    m_pc = 32'h8; m_pv = 1'b0; m_pa = 32'h0; m_red = 1'b0; m_mis = 1'b0; m_bad = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r_imm;
      r_imm = 32'($urandom_range(0, 511)) - 32'd256;
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, r_imm,
            ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095)));
      model_step();
      step();
      check_all($sformatf("rand%0d", i), m_pc, m_red, m_mis, m_bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
